// File: rtl/line_memory_responder_pkg.sv
// ============================================================================
//  Module     : line_memory_responder_pkg
//  Description: Shared constants for the data-cache <-> main-memory line
//               protocol: word/line sizes, default responder latency and the
//               responder state encodings.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_memory_responder_pkg;

   // Machine word width; line addresses drop the two byte-offset bits.
   localparam int WORD_SIZE       = 32;
   // Width of one data-cache line in bits.
   localparam int CACHE_LINE_SIZE = 128;
   // Default request-to-Ready latency of the line responder.
   localparam int MEM_LATENCY     = 5;

   // Responder states: accept, count down, present the Ready pulse.
   typedef enum logic [1:0] {
      MEMR_IDLE = 2'd0,
      MEMR_BUSY = 2'd1,
      MEMR_RESP = 2'd2
   } memr_state_e;

endpackage : line_memory_responder_pkg

`default_nettype wire

// File: rtl/line_memory_responder_latency_counter.sv
// ============================================================================
//  Module     : latency_counter
//  Description: Loadable down-counter timing a line transaction. Loads
//               LATENCY-2 on acceptance, decrements while enabled and flags
//               zero so the controller knows the next edge enters RESP.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module latency_counter #(
   parameter int LATENCY = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: load wins over decrement; saturate at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = CW'(LATENCY - 2);
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule : latency_counter

`default_nettype wire

// File: rtl/line_memory_responder.sv
// ============================================================================
//  Module     : line_memory_responder
//  Description: Fixed-latency line store answering data-cache fills and
//               write-backs. A request accepted in IDLE is serviced LATENCY
//               cycles later with a one-cycle Ready pulse; read data is
//               registered on Line_out and held until the next read.
//               Optional macro MEM_STATS_EN adds ReadCount/WriteCount ports
//               counting completed transactions.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_memory_responder
   import line_memory_responder_pkg::*;
#(
   parameter int LATENCY     = MEM_LATENCY,
   parameter int DEPTH_LINES = 256,
   parameter int LINE_BITS   = CACHE_LINE_SIZE,
   parameter int ADDR_BITS   = WORD_SIZE - 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] Address,
   input  logic                 Read,
   input  logic                 Write,
   input  logic [LINE_BITS-1:0] Line_in,
   output logic                 Ready,
   output logic [LINE_BITS-1:0] Line_out
`ifdef MEM_STATS_EN
   ,
   output logic [31:0]          ReadCount,
   output logic [31:0]          WriteCount
`endif
);

   localparam int IDX_BITS = $clog2(DEPTH_LINES);

   // Upper address bits select nothing; fold them away explicitly.
   logic unused_addr_hi;
   assign unused_addr_hi = ^Address[ADDR_BITS-1:IDX_BITS];

   logic [LINE_BITS-1:0] mem [DEPTH_LINES];

   memr_state_e          state_q, state_d;
   logic                 op_write_q, op_write_d;
   logic [IDX_BITS-1:0]  addr_q, addr_d;
   logic [LINE_BITS-1:0] line_q, line_d;
   logic [LINE_BITS-1:0] line_out_q, line_out_d;
   logic                 ready_q, ready_d;
`ifdef MEM_STATS_EN
   logic [31:0]          read_count_q, read_count_d;
   logic [31:0]          write_count_q, write_count_d;
`endif

   logic                 mem_we;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_zero;

   latency_counter #(
      .LATENCY (LATENCY)
   ) u_latency_counter (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   // Controller next state: accept in IDLE (write wins a tie), count in BUSY,
   // commit or fetch on the edge entering RESP, then return to IDLE.
   always_comb begin
      state_d       = state_q;
      op_write_d    = op_write_q;
      addr_d        = addr_q;
      line_d        = line_q;
      line_out_d    = line_out_q;
      ready_d       = 1'b0;
      mem_we        = 1'b0;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
`ifdef MEM_STATS_EN
      read_count_d  = read_count_q;
      write_count_d = write_count_q;
`endif
      case (state_q)
         MEMR_IDLE: begin
            if (Read || Write) begin
               op_write_d = Write;
               addr_d     = Address[IDX_BITS-1:0];
               line_d     = Line_in;
               cnt_load   = 1'b1;
               state_d    = MEMR_BUSY;
            end
         end
         MEMR_BUSY: begin
            if (cnt_zero) begin
               state_d = MEMR_RESP;
               ready_d = 1'b1;
               if (op_write_q) begin
                  mem_we = 1'b1;
`ifdef MEM_STATS_EN
                  write_count_d = write_count_q + 32'd1;
`endif
               end else begin
                  line_out_d = mem[addr_q];
`ifdef MEM_STATS_EN
                  read_count_d = read_count_q + 32'd1;
`endif
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         MEMR_RESP: begin
            state_d = MEMR_IDLE;
         end
         default: begin
            state_d = MEMR_IDLE;
         end
      endcase
   end

   // Control and output registers; reset returns to IDLE and drops any
   // transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= MEMR_IDLE;
         op_write_q    <= 1'b0;
         addr_q        <= '0;
         line_q        <= '0;
         line_out_q    <= '0;
         ready_q       <= 1'b0;
`ifdef MEM_STATS_EN
         read_count_q  <= '0;
         write_count_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         op_write_q    <= op_write_d;
         addr_q        <= addr_d;
         line_q        <= line_d;
         line_out_q    <= line_out_d;
         ready_q       <= ready_d;
`ifdef MEM_STATS_EN
         read_count_q  <= read_count_d;
         write_count_q <= write_count_d;
`endif
      end
   end

   // Line array: not cleared by reset; a reset edge blocks the commit so an
   // aborted write leaves the old contents.
   always_ff @(posedge clk) begin
      if (mem_we && rst) begin
         mem[addr_q] <= line_q;
      end
   end

   assign Ready    = ready_q;
   assign Line_out = line_out_q;
`ifdef MEM_STATS_EN
   assign ReadCount  = read_count_q;
   assign WriteCount = write_count_q;
`endif

endmodule : line_memory_responder

`default_nettype wire

// File: tb/tb_line_memory_responder.sv
// ============================================================================
//  Module     : tb_line_memory_responder
//  Description: Directed bench for line_memory_responder: a LATENCY=5 and a
//               LATENCY=2 instance driven from a vector table plus hand
//               sequences for tie-break, mid-transaction input changes and
//               reset abort.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_memory_responder;

   localparam int LB = 128;
   localparam int AB = 30;

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   logic [AB-1:0] addr1 = '0, addr2 = '0;
   logic          rd1 = 1'b0, wr1 = 1'b0, rd2 = 1'b0, wr2 = 1'b0;
   logic [LB-1:0] lin1 = '0, lin2 = '0;
   logic          rdy1, rdy2;
   logic [LB-1:0] lout1, lout2;
`ifdef MEM_STATS_EN
   logic [31:0]   rc1, wc1, rc2, wc2;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_rd   = 0;
   int exp_wr   = 0;

   always #5 clk = ~clk;

   line_memory_responder #(.LATENCY(5)) dut5 (
      .clk      (clk),
      .rst      (rst),
      .Address  (addr1),
      .Read     (rd1),
      .Write    (wr1),
      .Line_in  (lin1),
      .Ready    (rdy1),
      .Line_out (lout1)
`ifdef MEM_STATS_EN
      ,
      .ReadCount  (rc1),
      .WriteCount (wc1)
`endif
   );

   line_memory_responder #(.LATENCY(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .Address  (addr2),
      .Read     (rd2),
      .Write    (wr2),
      .Line_in  (lin2),
      .Ready    (rdy2),
      .Line_out (lout2)
`ifdef MEM_STATS_EN
      ,
      .ReadCount  (rc2),
      .WriteCount (wc2)
`endif
   );

   typedef struct {
      bit            rd;
      bit            wr;
      logic [AB-1:0] addr;
      logic [LB-1:0] data;
      logic [LB-1:0] exp_line;
   } vec_t;

   task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit rd, input bit wr,
                        input logic [AB-1:0] a, input logic [LB-1:0] d);
      if (!sel) begin
         rd1 = rd; wr1 = wr; addr1 = a; lin1 = d;
      end else begin
         rd2 = rd; wr2 = wr; addr2 = a; lin2 = d;
      end
   endtask

   function automatic logic get_ready(input bit sel);
      return sel ? rdy2 : rdy1;
   endfunction

   function automatic logic [LB-1:0] get_line(input bit sel);
      return sel ? lout2 : lout1;
   endfunction

   // Sample cycles 1..lat after acceptance: first Ready cycle, pulse count,
   // and Line_out in the final (Ready) cycle.
   task automatic observe(input bit sel, input int lat, output int first,
                          output int cnt, output logic [LB-1:0] line);
      first = 0;
      cnt   = 0;
      line  = '0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (get_ready(sel)) begin
            cnt++;
            if (first == 0) first = k;
         end
         if (k == lat) line = get_line(sel);
      end
   endtask

   // One full transaction: present request at a negedge, hold until Ready,
   // drop after the Ready cycle and confirm Ready is gone in cycle lat+1.
   task automatic run_txn(input bit sel, input int lat, input bit rd, input bit wr,
                          input logic [AB-1:0] a, input logic [LB-1:0] d,
                          input logic [LB-1:0] exp_line, input string name);
      int            first, cnt;
      logic [LB-1:0] line;
      drive(sel, rd, wr, a, d);
      @(posedge clk);
      observe(sel, lat, first, cnt, line);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b0, a, d);
      @(negedge clk);
      if (get_ready(sel)) cnt++;
      chk({name, "_ready_cycle"}, LB'(first), LB'(lat));
      chk({name, "_ready_width"}, LB'(cnt), LB'(1));
      chk({name, "_line_out"}, line, exp_line);
      if (!sel) begin
         if (wr) exp_wr++;
         else if (rd) exp_rd++;
      end
   endtask

   vec_t vecs[10];

   initial begin
      int            first, cnt;
      logic [LB-1:0] line;

      vecs[0] = '{1'b0, 1'b1, 30'h003, {16{8'hA5}}, '0};
      vecs[1] = '{1'b1, 1'b0, 30'h003, '0,          {16{8'hA5}}};
      vecs[2] = '{1'b0, 1'b1, 30'h004, {16{8'h5A}}, {16{8'hA5}}};
      vecs[3] = '{1'b1, 1'b0, 30'h004, '0,          {16{8'h5A}}};
      vecs[4] = '{1'b0, 1'b1, 30'h103, {16{8'h0F}}, {16{8'h5A}}};
      vecs[5] = '{1'b1, 1'b0, 30'h003, '0,          {16{8'h0F}}};
      vecs[6] = '{1'b0, 1'b1, 30'h0FF, {16{8'h96}}, {16{8'h0F}}};
      vecs[7] = '{1'b1, 1'b0, 30'h0FF, '0,          {16{8'h96}}};
      vecs[8] = '{1'b0, 1'b1, 30'h011, {16{8'hC3}}, {16{8'h96}}};
      vecs[9] = '{1'b0, 1'b1, 30'h020, {16{8'hE7}}, {16{8'h96}}};

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready5", LB'(rdy1), LB'(0));
      chk("reset_line5", lout1, '0);
      chk("reset_ready2", LB'(rdy2), LB'(0));
      chk("reset_line2", lout2, '0);
`ifdef MEM_STATS_EN
      chk("reset_rc", LB'(rc1), LB'(0));
      chk("reset_wc", LB'(wc1), LB'(0));
`endif
      rst = 1'b1;

      // Vector table on the LATENCY=5 instance.
      for (int i = 0; i < 10; i++) begin
         run_txn(1'b0, 5, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_line, $sformatf("vec%0d", i));
      end

      // Read and Write together: write first, held read accepted after.
      drive(1'b0, 1'b1, 1'b1, 30'h010, {8{16'h1234}});
      @(posedge clk);
      observe(1'b0, 5, first, cnt, line);
      chk("both_w_ready_cycle", LB'(first), LB'(5));
      chk("both_w_line_held", line, {16{8'h96}});
      exp_wr++;
      @(posedge clk);
      #1;
      wr1 = 1'b0;
      @(negedge clk);
      chk("both_gap_ready", LB'(rdy1), LB'(0));
      @(posedge clk);
      observe(1'b0, 5, first, cnt, line);
      chk("both_r_ready_cycle", LB'(first), LB'(5));
      chk("both_r_line", line, {8{16'h1234}});
      exp_rd++;
      @(posedge clk);
      #1;
      rd1 = 1'b0;
      @(negedge clk);
      chk("both_r_ready_off", LB'(rdy1), LB'(0));
      chk("both_r_line_hold", lout1, {8{16'h1234}});

      // Address/data changed during BUSY must not affect the write.
      drive(1'b0, 1'b0, 1'b1, 30'h010, {16{8'hD1}});
      @(posedge clk);
      #1;
      addr1 = 30'h011;
      lin1  = {16{8'h77}};
      observe(1'b0, 5, first, cnt, line);
      chk("midchg_ready_cycle", LB'(first), LB'(5));
      exp_wr++;
      @(posedge clk);
      #1;
      wr1 = 1'b0;
      @(negedge clk);
      run_txn(1'b0, 5, 1'b1, 1'b0, 30'h010, '0, {16{8'hD1}}, "midchg_rd010");
      run_txn(1'b0, 5, 1'b1, 1'b0, 30'h011, '0, {16{8'hC3}}, "midchg_rd011");

      // Reset in cycle 3 of a write to 0x020 aborts it.
      run_txn(1'b0, 5, 1'b1, 1'b0, 30'h020, '0, {16{8'hE7}}, "abort_pre");
      drive(1'b0, 1'b0, 1'b1, 30'h020, {16{8'h99}});
      @(posedge clk);
      cnt = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (rdy1) cnt++;
      end
      rst = 1'b0;
      wr1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("abort_line_zero", lout1, '0);
`ifdef MEM_STATS_EN
      chk("abort_rc_zero", LB'(rc1), LB'(0));
      chk("abort_wc_zero", LB'(wc1), LB'(0));
`endif
      exp_rd = 0;
      exp_wr = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (rdy1) cnt++;
      end
      chk("abort_no_ready", LB'(cnt), LB'(0));
      run_txn(1'b0, 5, 1'b1, 1'b0, 30'h020, '0, {16{8'hE7}}, "abort_post");

      // Post-reset traffic for the statistics counters.
      run_txn(1'b0, 5, 1'b0, 1'b1, 30'h030, {16{8'h11}}, {16{8'hE7}}, "stat_w0");
      run_txn(1'b0, 5, 1'b0, 1'b1, 30'h031, {16{8'h22}}, {16{8'hE7}}, "stat_w1");
      run_txn(1'b0, 5, 1'b1, 1'b0, 30'h031, '0, {16{8'h22}}, "stat_r0");
`ifdef MEM_STATS_EN
      chk("stat_wc", LB'(wc1), LB'(exp_wr));
      chk("stat_rc", LB'(rc1), LB'(exp_rd));
`endif

      // Minimum latency instance.
      run_txn(1'b1, 2, 1'b0, 1'b1, 30'h005, {16{8'h3C}}, '0, "lat2_w");
      run_txn(1'b1, 2, 1'b1, 1'b0, 30'h005, '0, {16{8'h3C}}, "lat2_r");
      run_txn(1'b1, 2, 1'b1, 1'b0, 30'h005, '0, {16{8'h3C}}, "lat2_r_again");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_line_memory_responder

`default_nettype wire

// File: doc/line_memory_responder.md
# line_memory_responder

Responder end of the data-cache ↔ main-memory line protocol: the block the data cache talks to when it issues line fills and write-backs. Each `Read` or `Write` request is a full cache line at a line address. The block services it with a fixed, parameterised latency (default 5 cycles) and answers with a one-cycle `Ready` pulse. It sits below the data cache in the memory stage and replaces the zero-latency behavioural line store.

## Interface
Parameters:
- `LATENCY`, 5: cycles from request acceptance to the `Ready` cycle, inclusive; legal range ≥2.
- `DEPTH_LINES`, 256: number of stored lines; power of two.
- `LINE_BITS`, `` `CACHE_LINE_SIZE ``: line width.
- `ADDR_BITS`, `` `WORD_SIZE-2 ``: line-address width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-low.
- `Address`  in  ADDR_BITS  line address; index = low log2(DEPTH_LINES) bits; upper bits ignored.
- `Read`  in  1  line-read request, level.
- `Write`  in  1  line-write request, level.
- `Line_in`  in  LINE_BITS  write data.
- `Ready`  out  1  completion pulse, one cycle.
- `Line_out`  out  LINE_BITS  read data; registered.
- `ReadCount`, `WriteCount`  out  32  completed transactions; present only with `MEM_STATS_EN`.

## Operation
- States:
  - IDLE: accepting requests.
  - BUSY: countdown in progress.
  - RESP: `Ready` = 1.
- IDLE with `Read | Write` = 1 at a clock edge:
  - Capture `Address`, `Line_in` and op type.
  - Load the counter with LATENCY-2.
  - Go to BUSY.
- Simultaneous `Read` and `Write` in IDLE: the write is accepted. A still-held `Read` is accepted as a new request once the block returns to IDLE.
- BUSY:
  - Decrement the counter each cycle.
  - At count 0, go to RESP.
  - At that same edge: a write commits the captured line to `mem[index]`; a read loads `Line_out` from `mem[index]`.
- RESP: `Ready` = 1 for exactly one cycle, then IDLE. No request is accepted in RESP.
- Initiator rule: the initiator deasserts the granted request in the cycle after `Ready`. A request still present in IDLE is treated as new.
- Inputs are ignored while in BUSY and RESP. Only the captured copies are used, so changes to `Address` or `Line_in` mid-transaction have no effect.
- `Line_out` holds its value until the next read completes; writes do not disturb it.
- Read-after-write to the same index returns the new data, because the commit precedes any later acceptance.
- Reset (`rst` = 0 at an edge), from any state:
  - Go to IDLE; `Ready` = 0; `Line_out` = 0; counters = 0.
  - An in-flight write is aborted without committing.
  - Array contents are not cleared.

## Timing
- Request sampled at edge E0 (cycle 0 in IDLE).
- BUSY occupies cycles 1..LATENCY-1.
- `Ready` is high in cycle LATENCY, i.e. after edge E0+LATENCY-1.
- `Line_out` is valid in the same cycle as `Ready`.
- Earliest next acceptance is at the end of cycle LATENCY+1.
- Throughput: one line per LATENCY+1 cycles.
- Reset values: `Ready` 0, `Line_out` 0, `ReadCount` 0, `WriteCount` 0, state IDLE.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `MEM_STATS_EN`.
- Defined:
  - `ReadCount` and `WriteCount` ports exist.
  - Each increments by 1 at the edge entering RESP for its op type.
  - Each wraps modulo 2^32.
  - Both clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Take `WORD_SIZE` and `CACHE_LINE_SIZE` from the shared constants header.
- Add the state encodings (`MEMR_IDLE`, `MEMR_BUSY`, `MEMR_RESP`) and the default latency `MEM_LATENCY` = 5 to the same header.
- One sub-module is natural: `latency_counter` (load, decrement, zero flag, width $clog2(LATENCY)). Storage array and FSM stay in the top module.

## Test plan
- Reset, then `Write` to addr 0x003 with `Line_in` = 0xA5…A5 held until `Ready` → `Ready` high exactly in cycle 5 after acceptance, one cycle wide; `Line_out` stays 0.
- `Read` addr 0x003 after the above → `Ready` in cycle 5; `Line_out` = 0xA5…A5 the same cycle, held afterwards.
- `Read` and `Write` both high to addr 0x010 with data 0x1234… → write serviced first; the held read is accepted two cycles after the first `Ready` and returns 0x1234….
- Change `Address` to 0x011 and `Line_in` during BUSY → the write lands at 0x010; 0x011 is unchanged.
- Assert `rst` = 0 in cycle 3 of a write to 0x020 → `Ready` never pulses; a later read of 0x020 returns the prior contents; `Line_out` = 0 after reset.
- With `MEM_STATS_EN`: 3 writes and 2 reads → `WriteCount` = 3, `ReadCount` = 2; both 0 after reset. Repeat with `LATENCY` = 2 → `Ready` in cycle 2.
